// File: rtl/sha256_stream_hash.sv
// Iterative multi-block SHA-256 engine, one compression round per clock, with
// optional built-in padding of block-aligned messages and optional SHA-256d.
module sha256_stream_hash #(
  parameter int CHUNKSIZE = 512,
  parameter int BLKCNT_W  = 32,
  parameter int DOUBLE_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  output logic                 inready,
  input  logic [CHUNKSIZE-1:0] datain,
  input  logic                 last,
  input  logic                 pad_en,
  input  logic                 dbl,
  output logic                 validoutput,
  input  logic                 out_ready,
  output logic [255:0]         final_hout
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ROUND, S_UPD, S_PAD, S_DBL, S_OUT} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t              st;
  logic [31:0]         w    [0:15];
  logic [31:0]         v    [0:7];
  logic [31:0]         hs   [0:7];
  logic [31:0]         hsum [0:7];
  logic [BLKCNT_W-1:0] cnt;
  logic [5:0]          rnd;
  logic                last_q, pad_q, dbl_q, pad_done, dbl_done;
  logic [31:0]         t1, t2, w_new;
  logic [63:0]         pad_len;

  // Round datapath, next schedule word, chaining sums and padding length field
  always_comb begin
    t1 = v[7] + big_s1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd] + w[0];
    t2 = big_s0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = sml_s1(w[14]) + w[9] + sml_s0(w[1]) + w[0];
    for (int j = 0; j < 8; j++) hsum[j] = hs[j] + v[j];
    pad_len = 64'(cnt) << 6'd9;
  end

  // Control FSM, working variables, message schedule and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_IDLE;
      inready     <= 1'b1;
      validoutput <= 1'b0;
      final_hout  <= 256'd0;
      cnt         <= '0;
      rnd         <= 6'd0;
      last_q      <= 1'b0;
      pad_q       <= 1'b0;
      dbl_q       <= 1'b0;
      pad_done    <= 1'b0;
      dbl_done    <= 1'b0;
      for (int j = 0; j < 8; j++) begin
        hs[j] <= IV[j];
        v[j]  <= IV[j];
      end
      for (int j = 0; j < 16; j++) w[j] <= 32'd0;
    end else begin
      case (st)
        S_IDLE: begin
          if (valid && inready) begin
            for (int j = 0; j < 8; j++) begin
              hs[j] <= IV[j];
              v[j]  <= IV[j];
            end
            for (int j = 0; j < 16; j++) w[j] <= datain[32*j +: 32];
            cnt      <= BLKCNT_W'(1);
            dbl_q    <= dbl & (DOUBLE_EN != 0);
            last_q   <= last;
            pad_q    <= pad_en & last;
            pad_done <= 1'b0;
            dbl_done <= 1'b0;
            rnd      <= 6'd0;
            inready  <= 1'b0;
            st       <= S_ROUND;
          end
        end
        S_WAIT: begin
          if (valid && inready) begin
            for (int j = 0; j < 8; j++) v[j] <= hs[j];
            for (int j = 0; j < 16; j++) w[j] <= datain[32*j +: 32];
            cnt     <= cnt + BLKCNT_W'(1);
            last_q  <= last;
            pad_q   <= pad_en & last;
            rnd     <= 6'd0;
            inready <= 1'b0;
            st      <= S_ROUND;
          end
        end
        S_ROUND: begin
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          for (int j = 0; j < 15; j++) w[j] <= w[j+1];
          w[15] <= w_new;
          rnd   <= rnd + 6'd1;
          if (rnd == 6'd63) st <= S_UPD;
        end
        S_UPD: begin
          for (int j = 0; j < 8; j++) hs[j] <= hsum[j];
          if (!last_q) begin
            inready <= 1'b1;
            st      <= S_WAIT;
          end else if (pad_q && !pad_done) begin
            st <= S_PAD;
          end else if (dbl_q && !dbl_done) begin
            st <= S_DBL;
          end else begin
            validoutput <= 1'b1;
            final_hout  <= {hsum[0], hsum[1], hsum[2], hsum[3], hsum[4], hsum[5], hsum[6], hsum[7]};
            st          <= S_OUT;
          end
        end
        S_PAD: begin
          w[0] <= 32'h80000000;
          for (int j = 1; j < 14; j++) w[j] <= 32'd0;
          w[14] <= pad_len[63:32];
          w[15] <= pad_len[31:0];
          for (int j = 0; j < 8; j++) v[j] <= hs[j];
          pad_done <= 1'b1;
          rnd      <= 6'd0;
          st       <= S_ROUND;
        end
        S_DBL: begin
          // Second pass hashes the 32-byte digest as a single padded block
          for (int j = 0; j < 8; j++) begin
            w[j]  <= hs[j];
            hs[j] <= IV[j];
            v[j]  <= IV[j];
          end
          w[8] <= 32'h80000000;
          for (int j = 9; j < 15; j++) w[j] <= 32'd0;
          w[15]    <= 32'h00000100;
          dbl_done <= 1'b1;
          rnd      <= 6'd0;
          st       <= S_ROUND;
        end
        S_OUT: begin
          if (out_ready) begin
            validoutput <= 1'b0;
            inready     <= 1'b1;
            pad_done    <= 1'b0;
            dbl_done    <= 1'b0;
            st          <= S_IDLE;
          end
        end
        default: begin
          validoutput <= 1'b0;
          inready     <= 1'b1;
          st          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_hash.sv
// Directed-vector bench for sha256_stream_hash: known digests, latencies,
// output back-pressure, multi-block chaining and mid-message reset.
module tb_sha256_stream_hash;

  logic         clk = 1'b0;
  logic         reset, valid, inready, last, pad_en, dbl, validoutput, out_ready;
  logic [511:0] datain;
  logic [255:0] final_hout;
  int           total = 0;
  int           bad = 0;
  int           lat;

  localparam logic [511:0] BLK_EMPTY = {480'd0, 32'h80000000};
  localparam logic [511:0] BLK_ABC   = {32'h00000018, 448'd0, 32'h61626380};
  localparam logic [511:0] BLK_ZERO  = 512'd0;
  localparam logic [511:0] BLK_PAD1  = {32'h00000200, 448'd0, 32'h80000000};

  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ZERO  = 256'hf5a5fd42d16a20302798ef6ed309979b43003d2320d9f0e8ea9831a92759fb4b;
  localparam logic [255:0] D_ABCD  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

  sha256_stream_hash dut (
    .clk(clk), .reset(reset), .valid(valid), .inready(inready), .datain(datain),
    .last(last), .pad_en(pad_en), .dbl(dbl), .validoutput(validoutput),
    .out_ready(out_ready), .final_hout(final_hout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer a block from a negedge and return at the negedge after the accepting edge
  task automatic send_block(input logic [511:0] d, input logic l, input logic p, input logic db);
    int n = 0;
    @(negedge clk);
    valid = 1'b1; datain = d; last = l; pad_en = p; dbl = db;
    while (!inready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_ready", 256'(inready), 256'd1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; last = 1'b0; pad_en = 1'b0; dbl = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!validoutput && n < 400);
  endtask

  task automatic take_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_vo_low"}, 256'(validoutput), 256'd0);
    check_val({tag, "_inready"}, 256'(inready), 256'd1);
  endtask

  task automatic run_msg(input string tag, input logic [511:0] d, input logic p, input logic db,
                         input int exp_lat, input logic [255:0] exp_dig);
    int n;
    send_block(d, 1'b1, p, db);
    wait_out(n);
    check_val({tag, "_latency"}, 256'(n), 256'(exp_lat));
    check_val({tag, "_digest"}, final_hout, exp_dig);
    take_out(tag);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; datain = 512'd0; last = 1'b0;
    pad_en = 1'b0; dbl = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_inready", 256'(inready), 256'd1);
    check_val("rst_validoutput", 256'(validoutput), 256'd0);
    check_val("rst_hout", final_hout, 256'd0);

    run_msg("empty", BLK_EMPTY, 1'b0, 1'b0, 65, D_EMPTY);
    run_msg("abc", BLK_ABC, 1'b0, 1'b0, 65, D_ABC);
    run_msg("zero_pad", BLK_ZERO, 1'b1, 1'b0, 131, D_ZERO);
    run_msg("abc_dbl", BLK_ABC, 1'b0, 1'b1, 131, D_ABCD);

    // Back-pressure: digest held while valid is pulsed with junk
    send_block(BLK_ABC, 1'b1, 1'b0, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 20; i++) begin
      valid = (i % 2 == 0);
      datain = {16{$urandom}};
      last = 1'b1;
      @(negedge clk);
      check_val("hold_digest", final_hout, D_ABC);
      check_val("hold_inready", 256'(inready), 256'd0);
    end
    valid = 1'b0; last = 1'b0;
    take_out("hold_release");
    repeat (70) @(negedge clk);
    check_val("no_capture", 256'(validoutput), 256'd0);

    // Two-block message: user supplies the padding block explicitly
    send_block(BLK_ZERO, 1'b0, 1'b1, 1'b0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!inready && lat < 400);
    check_val("multi_ready_lat", 256'(lat), 256'd65);
    run_msg("multi", BLK_PAD1, 1'b0, 1'b0, 65, D_ZERO);

    // Reset around round 30 of a non-last block aborts cleanly
    send_block(BLK_ZERO, 1'b0, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_inready", 256'(inready), 256'd1);
    check_val("abort_validoutput", 256'(validoutput), 256'd0);
    check_val("abort_hout", final_hout, 256'd0);
    run_msg("abc_rerun", BLK_ABC, 1'b0, 1'b0, 65, D_ABC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
